// File: rtl/maze_move_ctrl.sv
// Player-movement controller for the maze game.
// Turns keypad press events into grid moves, validates each move by reading
// the target cell from maze memory, and tracks win/loss/timeout and the
// number of accepted moves.
module maze_move_ctrl #(
    parameter int         X_W     = 3,
    parameter int         Y_W     = 3,
    parameter int         MOVE_W  = 8,
    parameter int         WRAP    = 0,
    parameter int         START_X = 0,
    parameter int         START_Y = 0,
    parameter logic [3:0] K_UP    = 4'd2,
    parameter logic [3:0] K_DOWN  = 4'd8,
    parameter logic [3:0] K_LEFT  = 4'd4,
    parameter logic [3:0] K_RIGHT = 4'd6,
    parameter logic [3:0] K_START = 4'd10
) (
    input  logic                 clk,
    input  logic                 nst,
    input  logic [3:0]           key_value,
    input  logic                 timeout,
    output logic [X_W+Y_W-1:0]   mem_addr,
    output logic                 mem_rd,
    input  logic [1:0]           mem_rdata,
    input  logic                 mem_rvalid,
    output logic [X_W-1:0]       pos_x,
    output logic [Y_W-1:0]       pos_y,
    output logic [MOVE_W-1:0]    moves,
    output logic [2:0]           game_state,
    output logic                 bump,
    output logic                 timecheckstop
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_FETCH = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        C_FLOOR = 2'd0,
        C_WALL  = 2'd1,
        C_GOAL  = 2'd2,
        C_TRAP  = 2'd3
    } cell_e;

    localparam logic [X_W-1:0]    X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]    Y_ONE    = Y_W'(1);
    localparam logic [X_W-1:0]    X_MAX    = '1;
    localparam logic [Y_W-1:0]    Y_MAX    = '1;
    localparam logic [X_W-1:0]    X_START  = X_W'(START_X);
    localparam logic [Y_W-1:0]    Y_START  = Y_W'(START_Y);
    localparam logic [MOVE_W-1:0] MOVE_ONE = MOVE_W'(1);
    localparam logic [MOVE_W-1:0] MOVE_MAX = '1;

    state_e                state_q,    state_d;
    logic [3:0]            key_q,      key_d;
    logic [3:0]            key_prev_q, key_prev_d;
    logic [X_W-1:0]        pos_x_q,    pos_x_d;
    logic [Y_W-1:0]        pos_y_q,    pos_y_d;
    logic [MOVE_W-1:0]     moves_q,    moves_d;
    logic [X_W+Y_W-1:0]    mem_addr_q, mem_addr_d;
    logic                  mem_rd_q,   mem_rd_d;
    logic                  bump_q,     bump_d;
    logic                  tcs_q,      tcs_d;

    logic                  key_evt;
    logic                  is_start;
    logic                  is_dir;
    logic                  off_grid;
    logic                  blocked;
    logic [X_W-1:0]        tgt_x;
    logic [Y_W-1:0]        tgt_y;
    logic [X_W-1:0]        fetch_x;
    logic [Y_W-1:0]        fetch_y;
    logic [MOVE_W-1:0]     moves_inc;

    // A press is the registered key leaving zero; holding or sliding between
    // two keys without a release produces nothing.
    assign key_evt   = (key_q != 4'd0) && (key_prev_q == 4'd0);
    assign is_start  = key_evt && (key_q == K_START);
    assign fetch_x   = mem_addr_q[X_W-1:0];
    assign fetch_y   = mem_addr_q[X_W +: Y_W];
    assign moves_inc = (moves_q == MOVE_MAX) ? moves_q : moves_q + MOVE_ONE;
    assign blocked   = off_grid && (WRAP == 0);

    // Target cell for the pending direction key; subtraction/addition wrap
    // modulo the grid size on their own, off_grid flags the edge crossing.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        tgt_x    = pos_x_q;
        tgt_y    = pos_y_q;
        off_grid = 1'b0;
        is_dir   = 1'b0;
        case (key_q)
            K_UP: begin
                is_dir   = key_evt;
                tgt_y    = pos_y_q - Y_ONE;
                off_grid = (pos_y_q == '0);
            end
            K_DOWN: begin
                is_dir   = key_evt;
                tgt_y    = pos_y_q + Y_ONE;
                off_grid = (pos_y_q == Y_MAX);
            end
            K_LEFT: begin
                is_dir   = key_evt;
                tgt_x    = pos_x_q - X_ONE;
                off_grid = (pos_x_q == '0);
            end
            K_RIGHT: begin
                is_dir   = key_evt;
                tgt_x    = pos_x_q + X_ONE;
                off_grid = (pos_x_q == X_MAX);
            end
            default: ;
        endcase
    end

    // Next-state and next-output decode for the game FSM.
    always_comb begin
        state_d    = state_q;
        key_d      = key_value;
        key_prev_d = key_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        moves_d    = moves_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        bump_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_start) begin
                    state_d = S_PLAY;
                    pos_x_d = X_START;
                    pos_y_d = Y_START;
                    moves_d = '0;
                end
            end
            S_PLAY: begin
                if (timeout) begin
                    state_d = S_LOSE;
                end else if (is_start) begin
                    pos_x_d = X_START;
                    pos_y_d = Y_START;
                    moves_d = '0;
                end else if (is_dir) begin
                    if (blocked) begin
                        bump_d = 1'b1;
                    end else begin
                        mem_addr_d = {tgt_y, tgt_x};
                        mem_rd_d   = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // Key events are dropped here; the edge registers keep
                // tracking so a key held through the fetch is not replayed.
                if (timeout) begin
                    state_d = S_LOSE;
                end else if (mem_rvalid) begin
                    case (cell_e'(mem_rdata))
                        C_WALL: begin
                            bump_d  = 1'b1;
                            state_d = S_PLAY;
                        end
                        C_GOAL: begin
                            pos_x_d = fetch_x;
                            pos_y_d = fetch_y;
                            moves_d = moves_inc;
                            state_d = S_WIN;
                        end
                        C_TRAP: begin
                            pos_x_d = fetch_x;
                            pos_y_d = fetch_y;
                            moves_d = moves_inc;
                            state_d = S_LOSE;
                        end
                        default: begin
                            pos_x_d = fetch_x;
                            pos_y_d = fetch_y;
                            moves_d = moves_inc;
                            state_d = S_PLAY;
                        end
                    endcase
                end
            end
            S_WIN, S_LOSE: begin
                if (is_start && !timeout) begin
                    state_d = S_PLAY;
                    pos_x_d = X_START;
                    pos_y_d = Y_START;
                    moves_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tcs_d = (state_d == S_WIN) || (state_d == S_LOSE);
    end

    // Single register stage for FSM state, key edge tracking and outputs.
    always_ff @(posedge clk or negedge nst) begin
        if (!nst) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            key_prev_q <= '0;
            pos_x_q    <= X_START;
            pos_y_q    <= Y_START;
            moves_q    <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            bump_q     <= 1'b0;
            tcs_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            key_q      <= key_d;
            key_prev_q <= key_prev_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            moves_q    <= moves_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            bump_q     <= bump_d;
            tcs_q      <= tcs_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_rd        = mem_rd_q;
    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign moves         = moves_q;
    assign game_state    = state_q;
    assign bump          = bump_q;
    assign timecheckstop = tcs_q;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Bench for maze_move_ctrl: instance A uses default parameters (edges block,
// 8-bit move counter); instance B uses WRAP=1 and a 2-bit move counter.
// Expected memory addresses are queued when a key is issued and checked by a
// monitor whenever the DUT raises mem_rd.
module tb_maze_move_ctrl;

    localparam logic [3:0] K_UP = 4'd2, K_DOWN = 4'd8, K_LEFT = 4'd4,
                           K_RIGHT = 4'd6, K_START = 4'd10;

    logic       clk = 1'b0;
    logic       nst_a, nst_b;
    logic [3:0] key_a, key_b;
    logic       timeout_a, timeout_b;
    logic [5:0] mem_addr_a, mem_addr_b;
    logic       mem_rd_a, mem_rd_b;
    logic [1:0] rdata_a, rdata_b, resp_rdata_a, resp_rdata_b;
    logic       rvalid_a, rvalid_b, resp_rvalid_a, resp_rvalid_b, man_rvalid_a;
    logic [2:0] pos_x_a, pos_x_b, pos_y_a, pos_y_b;
    logic [7:0] moves_a;
    logic [1:0] moves_b;
    logic [2:0] state_a, state_b;
    logic       bump_a, bump_b, tcs_a, tcs_b;

    logic [1:0] maze_a [64];
    logic [1:0] maze_b [64];
    int         lat_a = 1;
    bit         resp_en_a = 1'b1;
    logic [5:0] exp_a [$];
    logic [5:0] exp_b [$];
    int         bump_cnt_a = 0, bump_cnt_b = 0, exp_bump_a = 0;
    int         n_chk = 0, n_err = 0;

    assign rvalid_a = resp_rvalid_a | man_rvalid_a;
    assign rdata_a  = man_rvalid_a ? 2'd0 : resp_rdata_a;
    assign rvalid_b = resp_rvalid_b;
    assign rdata_b  = resp_rdata_b;

    always #5 clk = ~clk;

    maze_move_ctrl dut_a (
        .clk(clk), .nst(nst_a), .key_value(key_a), .timeout(timeout_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(rdata_a),
        .mem_rvalid(rvalid_a), .pos_x(pos_x_a), .pos_y(pos_y_a),
        .moves(moves_a), .game_state(state_a), .bump(bump_a),
        .timecheckstop(tcs_a)
    );

    maze_move_ctrl #(.WRAP(1), .MOVE_W(2)) dut_b (
        .clk(clk), .nst(nst_b), .key_value(key_b), .timeout(timeout_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(rdata_b),
        .mem_rvalid(rvalid_b), .pos_x(pos_x_b), .pos_y(pos_y_b),
        .moves(moves_b), .game_state(state_b), .bump(bump_b),
        .timecheckstop(tcs_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every mem_rd cycle must match the next queued address.
    always @(negedge clk) begin
        if (mem_rd_a) begin
            if (exp_a.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL mem_rd_a unexpected: addr 0x%0h, expected no read", mem_addr_a);
            end else begin
                check("mem_addr_a", 32'(mem_addr_a), 32'(exp_a.pop_front()));
            end
        end
        if (mem_rd_b) begin
            if (exp_b.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL mem_rd_b unexpected: addr 0x%0h, expected no read", mem_addr_b);
            end else begin
                check("mem_addr_b", 32'(mem_addr_b), 32'(exp_b.pop_front()));
            end
        end
        if (bump_a) bump_cnt_a++;
        if (bump_b) bump_cnt_b++;
    end

    // Memory responders: answer each read after the configured latency.
    initial begin
        logic [5:0] a;
        resp_rvalid_a = 1'b0; resp_rdata_a = 2'd0;
        forever begin
            @(negedge clk);
            if (mem_rd_a && resp_en_a) begin
                a = mem_addr_a;
                repeat (lat_a) @(negedge clk);
                resp_rdata_a = maze_a[a]; resp_rvalid_a = 1'b1;
                @(negedge clk);
                resp_rvalid_a = 1'b0;
            end
        end
    end

    initial begin
        logic [5:0] a;
        resp_rvalid_b = 1'b0; resp_rdata_b = 2'd0;
        forever begin
            @(negedge clk);
            if (mem_rd_b) begin
                a = mem_addr_b;
                @(negedge clk);
                resp_rdata_b = maze_b[a]; resp_rvalid_b = 1'b1;
                @(negedge clk);
                resp_rvalid_b = 1'b0;
            end
        end
    end

    task automatic press(input bit on_b, input logic [3:0] k);
        @(negedge clk);
        if (on_b) key_b = k; else key_a = k;
        repeat (2) @(negedge clk);
        if (on_b) key_b = 4'd0; else key_a = 4'd0;
        repeat (6) @(negedge clk);
    endtask

    task automatic press_a_exp(input logic [3:0] k, input logic [5:0] addr);
        exp_a.push_back(addr);
        press(1'b0, k);
    endtask

    task automatic press_b_exp(input logic [3:0] k, input logic [5:0] addr);
        exp_b.push_back(addr);
        press(1'b1, k);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            maze_a[i] = 2'd0;
            maze_b[i] = 2'd0;
        end
        maze_a[6'h0B] = 2'd1;  // wall at (3,1)
        maze_a[6'h05] = 2'd2;  // goal at (5,0)
        nst_a = 1'b0; nst_b = 1'b0;
        key_a = 4'd0; key_b = 4'd0;
        timeout_a = 1'b0; timeout_b = 1'b0;
        man_rvalid_a = 1'b0;
        repeat (3) @(negedge clk);
        nst_a = 1'b1; nst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst state", 32'(state_a), 0);
        check("rst pos_x", 32'(pos_x_a), 0);
        check("rst pos_y", 32'(pos_y_a), 0);
        check("rst moves", 32'(moves_a), 0);
        check("rst mem_addr", 32'(mem_addr_a), 0);
        check("rst mem_rd", 32'(mem_rd_a), 0);
        check("rst tcs", 32'(tcs_a), 0);

        // Direction keys before START are ignored in IDLE
        press(1'b0, K_RIGHT);
        check("idle ignores key", 32'(state_a), 0);
        press(1'b0, K_START);
        check("start -> PLAY", 32'(state_a), 1);

        // Blocked edges: bump, no memory read
        press(1'b0, K_UP);    exp_bump_a++;
        check("edge up bump", 32'(bump_cnt_a), 32'(exp_bump_a));
        press(1'b0, K_LEFT);  exp_bump_a++;
        check("edge left bump", 32'(bump_cnt_a), 32'(exp_bump_a));
        check("edge pos", 32'({pos_y_a, pos_x_a}), 0);
        check("edge moves", 32'(moves_a), 0);

        // Three floor moves to the right
        press_a_exp(K_RIGHT, 6'h01);
        press_a_exp(K_RIGHT, 6'h02);
        press_a_exp(K_RIGHT, 6'h03);
        check("right3 pos_x", 32'(pos_x_a), 3);
        check("right3 moves", 32'(moves_a), 3);
        check("right3 state", 32'(state_a), 1);

        // Wall below (3,0)
        press_a_exp(K_DOWN, 6'h0B); exp_bump_a++;
        check("wall bump", 32'(bump_cnt_a), 32'(exp_bump_a));
        check("wall pos", 32'({pos_y_a, pos_x_a}), 32'({3'd0, 3'd3}));
        check("wall moves", 32'(moves_a), 3);

        // Goal at (5,0)
        press_a_exp(K_RIGHT, 6'h04);
        press_a_exp(K_RIGHT, 6'h05);
        check("goal state", 32'(state_a), 3);
        check("goal tcs", 32'(tcs_a), 1);
        check("goal pos_x", 32'(pos_x_a), 5);
        check("goal moves", 32'(moves_a), 5);
        press(1'b0, K_LEFT);
        check("win frozen pos", 32'(pos_x_a), 5);
        check("win frozen state", 32'(state_a), 3);

        // Restart from WIN
        press(1'b0, K_START);
        check("restart state", 32'(state_a), 1);
        check("restart pos", 32'({pos_y_a, pos_x_a}), 0);
        check("restart moves", 32'(moves_a), 0);
        check("restart tcs", 32'(tcs_a), 0);

        // Timeout during FETCH, late rvalid ignored
        resp_en_a = 1'b0;
        exp_a.push_back(6'h01);
        @(negedge clk); key_a = K_RIGHT;
        repeat (2) @(negedge clk);
        timeout_a = 1'b1; key_a = 4'd0;
        repeat (2) @(negedge clk);
        man_rvalid_a = 1'b1;
        @(negedge clk); man_rvalid_a = 1'b0;
        repeat (2) @(negedge clk);
        check("tmo state", 32'(state_a), 4);
        check("tmo pos", 32'({pos_y_a, pos_x_a}), 0);
        check("tmo moves", 32'(moves_a), 0);
        check("tmo tcs", 32'(tcs_a), 1);
        resp_en_a = 1'b1;
        press(1'b0, K_START);
        check("start w/ timeout", 32'(state_a), 4);
        timeout_a = 1'b0;
        press(1'b0, K_START);
        check("lose restart state", 32'(state_a), 1);
        check("lose restart moves", 32'(moves_a), 0);

        // Held key gives exactly one move
        exp_a.push_back(6'h01);
        @(negedge clk); key_a = K_RIGHT;
        repeat (300) @(negedge clk);
        key_a = 4'd0;
        repeat (4) @(negedge clk);
        check("hold pos_x", 32'(pos_x_a), 1);
        check("hold moves", 32'(moves_a), 1);

        // Reset in the middle of a fetch, response arrives after reset
        lat_a = 5;
        exp_a.push_back(6'h02);
        @(negedge clk); key_a = K_RIGHT;
        repeat (2) @(negedge clk);
        key_a = 4'd0;
        nst_a = 1'b0;
        #1;
        check("mid-fetch rst state", 32'(state_a), 0);
        check("mid-fetch rst mem_rd", 32'(mem_rd_a), 0);
        repeat (2) @(negedge clk);
        nst_a = 1'b1;
        repeat (10) @(negedge clk);
        check("late rvalid state", 32'(state_a), 0);
        check("late rvalid pos", 32'({pos_y_a, pos_x_a}), 0);
        check("late rvalid moves", 32'(moves_a), 0);

        // Instance B: wrap-around and 2-bit saturating move counter
        press(1'b1, K_START);
        check("b start", 32'(state_b), 1);
        press_b_exp(K_UP, 6'h38);
        check("b wrap up pos", 32'({pos_y_b, pos_x_b}), 32'({3'd7, 3'd0}));
        press_b_exp(K_LEFT, 6'h3F);
        check("b wrap left pos_x", 32'(pos_x_b), 7);
        press_b_exp(K_RIGHT, 6'h38);
        press_b_exp(K_DOWN, 6'h00);
        check("b moves 4th", 32'(moves_b), 3);
        press_b_exp(K_DOWN, 6'h08);
        check("b moves sat", 32'(moves_b), 3);
        check("b pos", 32'({pos_y_b, pos_x_b}), 32'({3'd1, 3'd0}));
        check("b bumps", 32'(bump_cnt_b), 0);

        // Every queued read must have been seen
        check("exp_a drained", 32'(exp_a.size()), 0);
        check("exp_b drained", 32'(exp_b.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
